// File: rtl/mux_tree_arbiter_pkg.sv
// mux_tree_arbiter_pkg: shared FSM states and sizing helpers for the mux tree arbiter.
package mux_tree_arbiter_pkg;

    typedef enum logic [1:0] {IDLE, GRANT, DRAIN} state_t;

    function automatic int num_src(input int levels);
        return 4 ** levels;
    endfunction

    function automatic int clog2(input int v);
        int r;
        for (r = 0; (1 << r) < v; r++) begin end
        return r;
    endfunction

endpackage

// File: rtl/mux_tree_arbiter_rr_prio_sel.sv
// rr_prio_sel: rotate-priority-encode-unrotate; first set req bit at or above ptr, wrapping.
module rr_prio_sel
    import mux_tree_arbiter_pkg::*;
#(
    parameter int N  = 16,
    parameter int IW = 4
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [IW-1:0] win,
    output logic          any
);

    logic [N-1:0]  rot;
    logic [IW-1:0] off;

    always_comb begin
        rot = N'({req, req} >> ptr);
        off = '0;
        for (int i = N - 1; i >= 0; i--)
            if (rot[i]) off = IW'(i);
        win = ptr + off;
        any = |req;
    end

endmodule

// File: rtl/mux_tree_arbiter.sv
// mux_tree_arbiter: round-robin packet arbiter driving staggered selects of a pipelined 4:1 mux tree.
module mux_tree_arbiter
    import mux_tree_arbiter_pkg::*;
#(
    parameter int LEVELS       = 2,
    parameter int ENABLE_DELAY = 0,
    localparam int N           = num_src(LEVELS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N-1:0]        req,
    output logic [N-1:0]        gnt,
    input  logic                done,
    input  logic                src_vld,
    output logic [2*LEVELS-1:0] tree_sel,
    output logic                out_vld,
    output logic                busy
);

    localparam int IW = 2 * LEVELS;
    localparam int L  = ENABLE_DELAY ? LEVELS : 0;
    localparam int CW = clog2(LEVELS + 1);

    state_t        state;
    logic [IW-1:0] ptr;
    logic [IW-1:0] stg [LEVELS];
    logic [CW-1:0] cnt;
    logic [LEVELS-1:0] vsr;
    logic [IW-1:0] win;
    logic          any;
    logic          v;

    rr_prio_sel #(.N(N), .IW(IW)) u_sel (
        .req(req),
        .ptr(ptr),
        .win(win),
        .any(any)
    );

    assign v       = src_vld && |gnt;
    assign busy    = state != IDLE;
    assign out_vld = ENABLE_DELAY ? vsr[LEVELS-1] : v;

    // stg[k] is the granted index k cycles ago, matching level k's register depth
    always_comb begin
        tree_sel = '0;
        for (int k = 0; k < LEVELS; k++)
            tree_sel[2*k +: 2] = ENABLE_DELAY ? stg[k][2*k +: 2] : stg[0][2*k +: 2];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            gnt   <= '0;
            ptr   <= '0;
            cnt   <= '0;
            vsr   <= '0;
            for (int j = 0; j < LEVELS; j++) stg[j] <= '0;
        end else begin
            vsr <= LEVELS'({vsr, v});
            for (int j = 1; j < LEVELS; j++) stg[j] <= stg[j-1];
            case (state)
                IDLE: if (any) begin
                    gnt    <= N'(1) << win;
                    stg[0] <= win;
                    state  <= GRANT;
                end
                GRANT: if (done) begin
                    gnt   <= '0;
                    ptr   <= stg[0] + IW'(1);
                    cnt   <= CW'(L - 1);
                    state <= L > 0 ? DRAIN : IDLE;
                end
                DRAIN: begin
                    cnt <= cnt - CW'(1);
                    if (cnt == '0) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
